// File: rtl/mac_avl_arbiter.sv
// Round-robin arbiter sharing the MAC Avalon-MM register port between the
// configuration sequencer (port 0) and the status poller (port 1), with a busy timeout.
module mac_avl_arbiter #(
    parameter int unsigned             ADDR_WIDTH     = 8,
    parameter int unsigned             DATA_WIDTH     = 32,
    parameter int unsigned             TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0]   TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rq0_read_req,
    input  logic                  rq0_write_req,
    input  logic [ADDR_WIDTH-1:0] rq0_address,
    input  logic [DATA_WIDTH-1:0] rq0_writedata,
    output logic                  rq0_busy,
    output logic [DATA_WIDTH-1:0] rq0_readdata,
    output logic                  rq0_error,
    input  logic                  rq1_read_req,
    input  logic                  rq1_write_req,
    input  logic [ADDR_WIDTH-1:0] rq1_address,
    input  logic [DATA_WIDTH-1:0] rq1_writedata,
    output logic                  rq1_busy,
    output logic [DATA_WIDTH-1:0] rq1_readdata,
    output logic                  rq1_error,
    input  logic                  avl_busy,
    input  logic [DATA_WIDTH-1:0] avl_readdata,
    output logic [ADDR_WIDTH-1:0] avl_address,
    output logic [DATA_WIDTH-1:0] avl_writedata,
    output logic                  avl_read_req,
    output logic                  avl_write_req
);

    localparam int unsigned     CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t                state, state_d;
    logic                  grant, grant_d;
    logic                  last_grant, last_grant_d;
    logic [CW-1:0]         count, count_d;
    logic [ADDR_WIDTH-1:0] avl_address_d;
    logic [DATA_WIDTH-1:0] avl_writedata_d;
    logic                  avl_read_req_d, avl_write_req_d;
    logic                  rq0_busy_d, rq1_busy_d;
    logic                  rq0_error_d, rq1_error_d;
    logic [DATA_WIDTH-1:0] rq0_readdata_d, rq1_readdata_d;
    logic                  req0, req1, pick, sel_write, finish, load;
    logic [DATA_WIDTH-1:0] resp_data;

    assign req0 = rq0_read_req | rq0_write_req;
    assign req1 = rq1_read_req | rq1_write_req;

    always_comb begin
        state_d         = state;
        grant_d         = grant;
        last_grant_d    = last_grant;
        count_d         = count;
        avl_address_d   = avl_address;
        avl_writedata_d = avl_writedata;
        avl_read_req_d  = avl_read_req;
        avl_write_req_d = avl_write_req;
        rq0_busy_d      = rq0_busy;
        rq1_busy_d      = rq1_busy;
        rq0_error_d     = rq0_error;
        rq1_error_d     = rq1_error;
        rq0_readdata_d  = rq0_readdata;
        rq1_readdata_d  = rq1_readdata;
        pick            = 1'b0;
        sel_write       = 1'b0;
        // A normal completion wins over a timeout landing on the same cycle.
        finish          = !avl_busy || (count == CNT_LAST);
        load            = avl_busy || avl_read_req;
        resp_data       = avl_busy ? TIMEOUT_DATA : avl_readdata;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    pick            = (req0 && req1) ? ~last_grant : req1;
                    sel_write       = pick ? rq1_write_req : rq0_write_req;
                    grant_d         = pick;
                    avl_address_d   = pick ? rq1_address : rq0_address;
                    avl_writedata_d = pick ? rq1_writedata : rq0_writedata;
                    avl_write_req_d = sel_write;
                    avl_read_req_d  = !sel_write;
                    state_d         = XFER;
                end
            end
            XFER: begin
                if (finish) begin
                    avl_read_req_d  = 1'b0;
                    avl_write_req_d = 1'b0;
                    state_d         = RESP;
                    if (grant) begin
                        rq1_busy_d  = 1'b0;
                        rq1_error_d = avl_busy;
                        if (load) rq1_readdata_d = resp_data;
                    end else begin
                        rq0_busy_d  = 1'b0;
                        rq0_error_d = avl_busy;
                        if (load) rq0_readdata_d = resp_data;
                    end
                end else begin
                    count_d = count + CW'(1);
                end
            end
            RESP: begin
                rq0_busy_d   = 1'b1;
                rq1_busy_d   = 1'b1;
                rq0_error_d  = 1'b0;
                rq1_error_d  = 1'b0;
                last_grant_d = grant;
                count_d      = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            count         <= '0;
            avl_address   <= '0;
            avl_writedata <= '0;
            avl_read_req  <= 1'b0;
            avl_write_req <= 1'b0;
            rq0_busy      <= 1'b1;
            rq1_busy      <= 1'b1;
            rq0_error     <= 1'b0;
            rq1_error     <= 1'b0;
            rq0_readdata  <= '0;
            rq1_readdata  <= '0;
        end else begin
            state         <= state_d;
            grant         <= grant_d;
            last_grant    <= last_grant_d;
            count         <= count_d;
            avl_address   <= avl_address_d;
            avl_writedata <= avl_writedata_d;
            avl_read_req  <= avl_read_req_d;
            avl_write_req <= avl_write_req_d;
            rq0_busy      <= rq0_busy_d;
            rq1_busy      <= rq1_busy_d;
            rq0_error     <= rq0_error_d;
            rq1_error     <= rq1_error_d;
            rq0_readdata  <= rq0_readdata_d;
            rq1_readdata  <= rq1_readdata_d;
        end
    end

endmodule

// File: tb/tb_mac_avl_arbiter.sv
// Self-checking bench for mac_avl_arbiter: vector table plus scoreboard of
// expected completions, with a scripted MAC responder.
module tb_mac_avl_arbiter;

    logic        clock, reset;
    logic        rq0_read_req, rq0_write_req, rq1_read_req, rq1_write_req;
    logic [7:0]  rq0_address, rq1_address, avl_address;
    logic [31:0] rq0_writedata, rq1_writedata, rq0_readdata, rq1_readdata;
    logic [31:0] avl_readdata, avl_writedata;
    logic        rq0_busy, rq1_busy, rq0_error, rq1_error;
    logic        avl_busy, avl_read_req, avl_write_req;

    mac_avl_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16),
                      .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
        .clock(clock), .reset(reset),
        .rq0_read_req(rq0_read_req), .rq0_write_req(rq0_write_req),
        .rq0_address(rq0_address), .rq0_writedata(rq0_writedata),
        .rq0_busy(rq0_busy), .rq0_readdata(rq0_readdata), .rq0_error(rq0_error),
        .rq1_read_req(rq1_read_req), .rq1_write_req(rq1_write_req),
        .rq1_address(rq1_address), .rq1_writedata(rq1_writedata),
        .rq1_busy(rq1_busy), .rq1_readdata(rq1_readdata), .rq1_error(rq1_error),
        .avl_busy(avl_busy), .avl_readdata(avl_readdata),
        .avl_address(avl_address), .avl_writedata(avl_writedata),
        .avl_read_req(avl_read_req), .avl_write_req(avl_write_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        port;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    typedef struct {
        logic        port;
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] mac_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cycles;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[9];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, xfer_cnt = 0, mac_lat = 0;
    logic [31:0] mac_rdata = '0;
    int          rem0 = 0, rem1 = 0, rd_cnt = 0, wr_cnt = 0, lo0 = 0, lo1 = 0;
    int          done_cyc = -1, start_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // MAC model: busy stays high for the first mac_lat cycles of each request.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (avl_read_req || avl_write_req) begin
            xfer_cnt++;
            avl_busy = (xfer_cnt <= mac_lat);
        end else begin
            xfer_cnt = 0;
            avl_busy = 1'b1;
        end
        avl_readdata = mac_rdata;
    endtask

    task automatic complete(input logic p, input logic [31:0] rd, input logic er);
        sb_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cpl_unexpected: got completion on port %0d expected none", p);
        end else begin
            e = sb.pop_front();
            chk("cpl_port", {63'b0, p}, {63'b0, e.port});
            chk("cpl_rdata", {32'b0, rd}, {32'b0, e.rdata});
            chk("cpl_error", {63'b0, er}, {63'b0, e.err});
        end
        done_cyc = cyc;
        if (p == 1'b0) begin
            lo0++;
            rem0--;
            if (rem0 <= 0) begin rq0_read_req = 1'b0; rq0_write_req = 1'b0; end
        end else begin
            lo1++;
            rem1--;
            if (rem1 <= 0) begin rq1_read_req = 1'b0; rq1_write_req = 1'b0; end
        end
    endtask

    task automatic service();
        if (avl_read_req) rd_cnt++;
        if (avl_write_req) wr_cnt++;
        if (xfer_cnt == 1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mst_unexpected: got master request expected none");
            end else begin
                chk("mst_addr", {56'b0, avl_address}, {56'b0, sb[0].addr});
                chk("mst_write", {63'b0, avl_write_req}, {63'b0, sb[0].wr});
                chk("mst_read", {63'b0, avl_read_req}, {63'b0, !sb[0].wr});
                if (sb[0].wr) chk("mst_wdata", {32'b0, avl_writedata}, {32'b0, sb[0].wdata});
            end
        end
        if (!rq0_busy) complete(1'b0, rq0_readdata, rq0_error);
        if (!rq1_busy) complete(1'b1, rq1_readdata, rq1_error);
    endtask

    task automatic run_until(input int budget);
        start_cyc = cyc;
        done_cyc  = -1;
        while (cyc - start_cyc < budget) begin
            step();
            service();
            if (rem0 <= 0 && rem1 <= 0 && done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        if (rem0 > 0 || rem1 > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: got %0d/%0d pending expected 0/0", rem0, rem1);
        end
    endtask

    task automatic push(input logic p, input logic [7:0] a, input logic [31:0] d,
                        input logic w, input logic [31:0] r, input logic e);
        sb_t s;
        s.port = p; s.addr = a; s.wdata = d; s.wr = w; s.rdata = r; s.err = e;
        sb.push_back(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        //          port  rd    wr    addr   wdata          lat   mac_rdata      exp_rdata      err   cyc
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h02, 32'h0000_0043, 0,    32'h0,         32'h1111_2222, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h17, 32'h0,         3,    32'h1234_5678, 32'h1234_5678, 1'b0, 4};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h05, 32'h0,         1,    32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 2};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h09, 32'h0000_0055, 0,    32'hFFFF_FFFF, 32'hA5A5_0001, 1'b0, 1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h30, 32'hCAFE_F00D, 2,    32'h0,         32'h1234_5678, 1'b0, 3};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h11, 32'h0,         15,   32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 16};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h20, 32'h0,         1000, 32'h0,         32'hDEAD_BEEF, 1'b1, 16};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 8'h21, 32'h0,         0,    32'h0000_0077, 32'h0000_0077, 1'b0, 1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 8'h3C, 32'h0000_0001, 1000, 32'h0,         32'hDEAD_BEEF, 1'b1, 16};

        reset = 1'b1;
        rq0_read_req = 1'b0; rq0_write_req = 1'b0; rq0_address = '0; rq0_writedata = '0;
        rq1_read_req = 1'b0; rq1_write_req = 1'b0; rq1_address = '0; rq1_writedata = '0;
        avl_busy = 1'b1; avl_readdata = '0;
        repeat (3) step();

        chk("rst_avl_read_req", {63'b0, avl_read_req}, 64'd0);
        chk("rst_avl_write_req", {63'b0, avl_write_req}, 64'd0);
        chk("rst_avl_address", {56'b0, avl_address}, 64'd0);
        chk("rst_avl_writedata", {32'b0, avl_writedata}, 64'd0);
        chk("rst_rq0_busy", {63'b0, rq0_busy}, 64'd1);
        chk("rst_rq1_busy", {63'b0, rq1_busy}, 64'd1);
        chk("rst_rq0_readdata", {32'b0, rq0_readdata}, 64'd0);
        chk("rst_rq1_readdata", {32'b0, rq1_readdata}, 64'd0);
        chk("rst_rq0_error", {63'b0, rq0_error}, 64'd0);
        chk("rst_rq1_error", {63'b0, rq1_error}, 64'd0);

        // Both ports requesting from reset release: grants must alternate 0,1,0,1.
        reset = 1'b0;
        mac_lat = 0;
        mac_rdata = 32'h1111_2222;
        rq0_read_req = 1'b1; rq0_address = 8'h0A;
        rq1_read_req = 1'b1; rq1_address = 8'h1B;
        rem0 = 2; rem1 = 2;
        push(1'b0, 8'h0A, 32'h0, 1'b0, 32'h1111_2222, 1'b0);
        push(1'b1, 8'h1B, 32'h0, 1'b0, 32'h1111_2222, 1'b0);
        push(1'b0, 8'h0A, 32'h0, 1'b0, 32'h1111_2222, 1'b0);
        push(1'b1, 8'h1B, 32'h0, 1'b0, 32'h1111_2222, 1'b0);
        run_until(80);
        chk("rr_sb_drained", 64'(sb.size()), 64'd0);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            rd_cnt = 0; wr_cnt = 0; lo0 = 0; lo1 = 0;
            mac_lat = v.lat;
            mac_rdata = v.mac_rdata;
            push(v.port, v.addr, v.wdata, v.wr, v.exp_rdata, v.exp_err);
            if (v.port == 1'b0) begin
                rq0_read_req = v.rd; rq0_write_req = v.wr;
                rq0_address = v.addr; rq0_writedata = v.wdata; rem0 = 1;
            end else begin
                rq1_read_req = v.rd; rq1_write_req = v.wr;
                rq1_address = v.addr; rq1_writedata = v.wdata; rem1 = 1;
            end
            run_until(60);
            chk($sformatf("v%0d_latency", i), 64'(done_cyc - start_cyc), 64'(v.exp_cycles + 1));
            chk($sformatf("v%0d_read_cycles", i), 64'(rd_cnt), v.wr ? 64'd0 : 64'(v.exp_cycles));
            chk($sformatf("v%0d_write_cycles", i), 64'(wr_cnt), v.wr ? 64'(v.exp_cycles) : 64'd0);
            chk($sformatf("v%0d_own_pulse", i), 64'(v.port ? lo1 : lo0), 64'd1);
            chk($sformatf("v%0d_other_busy", i), 64'(v.port ? lo0 : lo1), 64'd0);
        end

        // Reset during XFER discards the transaction; the next tie goes to port 0.
        mac_lat = 1000;
        rq1_read_req = 1'b1; rq1_address = 8'h44;
        repeat (3) step();
        chk("rst_mid_pre_req", {63'b0, avl_read_req}, 64'd1);
        reset = 1'b1;
        rq1_read_req = 1'b0;
        step();
        chk("rst_mid_read_req", {63'b0, avl_read_req}, 64'd0);
        chk("rst_mid_write_req", {63'b0, avl_write_req}, 64'd0);
        chk("rst_mid_rq0_busy", {63'b0, rq0_busy}, 64'd1);
        chk("rst_mid_rq1_busy", {63'b0, rq1_busy}, 64'd1);
        reset = 1'b0;
        mac_lat = 0;
        mac_rdata = 32'h0000_5A5A;
        lo0 = 0; lo1 = 0;
        rq0_read_req = 1'b1; rq0_write_req = 1'b0; rq0_address = 8'h50;
        rq1_read_req = 1'b1; rq1_write_req = 1'b0; rq1_address = 8'h51;
        rem0 = 1; rem1 = 1;
        push(1'b0, 8'h50, 32'h0, 1'b0, 32'h0000_5A5A, 1'b0);
        push(1'b1, 8'h51, 32'h0, 1'b0, 32'h0000_5A5A, 1'b0);
        run_until(60);
        chk("post_rst_sb_drained", 64'(sb.size()), 64'd0);
        chk("post_rst_rq0_pulse", 64'(lo0), 64'd1);
        chk("post_rst_rq1_pulse", 64'(lo1), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
